// File: rtl/br_pkg.sv
// br_pkg: constants and FSM encoding shared by the register bank and its loader
package br_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    typedef enum logic [1:0] {IDLE, LOAD, FIN} br_ld_state_t;
endpackage

// File: rtl/br_loader.sv
// br_loader: turns a valid/ready word stream into one-cycle register bank writes
module br_loader
    import br_pkg::*;
#(
    parameter int DATA_W = br_pkg::DATA_W,
    parameter int ADDR_W = br_pkg::ADDR_W,
    parameter int NREG   = br_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_reg,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] WR,
    output logic [DATA_W-1:0] DW,
    output logic              RegEn,
    output logic              busy,
    output logic              done,
    output logic              err
);
    br_ld_state_t state, nxt;
    logic [ADDR_W-1:0] addr, addr_n, wr_n;
    logic [ADDR_W:0]   rem, rem_n;
    logic [DATA_W-1:0] dw_n;
    logic              regen_n, acc, legal, err_n;

    // in_ready is registered as (state == LOAD), so it doubles as the LOAD qualifier
    assign acc   = in_valid && in_ready;
    assign legal = (count != '0) && (count <= (ADDR_W+1)'(NREG));
    assign err_n = (state == IDLE) && start && !legal;

    always_comb begin
        nxt     = state;
        addr_n  = addr;
        rem_n   = rem;
        regen_n = 1'b0;
        wr_n    = WR;
        dw_n    = DW;
        case (state)
            IDLE: if (start && legal) begin
                nxt    = LOAD;
                addr_n = base_reg;
                rem_n  = count;
            end
            LOAD: begin
                if (acc) begin
                    addr_n = addr + 1'b1;
                    rem_n  = rem - 1'b1;
                end
                // register 0 is hardwired: the word still counts but is dropped
                if (acc && addr != ZERO_REG) begin
                    regen_n = 1'b1;
                    wr_n    = addr;
                    dw_n    = in_data;
                end
                nxt = abort ? IDLE : (acc && rem == (ADDR_W+1)'(1)) ? FIN : LOAD;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            WR       <= '0;
            DW       <= '0;
            RegEn    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= nxt;
            addr     <= addr_n;
            rem      <= rem_n;
            WR       <= wr_n;
            DW       <= dw_n;
            RegEn    <= regen_n;
            in_ready <= nxt == LOAD;
            busy     <= nxt != IDLE;
            done     <= nxt == FIN;
            err      <= err_n;
        end
    end
endmodule

// File: tb/tb_br_loader.sv
// tb_br_loader: scoreboard bench for br_loader
module tb_br_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base_reg = '0;
    logic [5:0]  count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic [4:0]  WR;
    logic [31:0] DW;
    logic        RegEn, busy, done, err;

    logic [36:0] exp_q[$];
    logic [4:0]  tb_addr = '0;
    int vectors = 0;
    int miscompares = 0;
    int regen_cnt = 0;
    int snap;

    br_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_reg(base_reg), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .abort(abort),
        .WR(WR), .DW(DW), .RegEn(RegEn), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every write pulse must match the oldest expected write
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n && RegEn) begin
            regen_cnt++;
            if (exp_q.size() == 0) check("spurious_regen", {27'd0, WR}, 32'hffff_ffff);
            else begin
                e = exp_q.pop_front();
                check("wr", {27'd0, WR}, {27'd0, e[36:32]});
                check("dw", DW, e[31:0]);
            end
        end
    end

    task automatic start_burst(input logic [4:0] b, input logic [5:0] c);
        @(negedge clk);
        start = 1'b1; base_reg = b; count = c; tb_addr = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed(input logic [31:0] d, input logic ab = 1'b0);
        check("in_ready_load", in_ready, 1);
        in_valid = 1'b1; in_data = d; abort = ab;
        if (tb_addr != 5'd0) exp_q.push_back({tb_addr, d});
        tb_addr = tb_addr + 5'd1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic expect_done;
        check("done_pulse", done, 1);
        check("busy_fin", busy, 1);
        check("in_ready_fin", in_ready, 0);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("q_empty", exp_q.size(), 0);
    endtask

    task automatic illegal(input logic [5:0] c);
        @(negedge clk);
        start = 1'b1; count = c;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("busy_err", busy, 0);
        @(negedge clk);
        check("err_clear", err, 0);
        check("busy_err2", busy, 0);
    endtask

    initial begin
        #1;
        check("rst_regen", RegEn, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr", {27'd0, WR}, 0);
        check("rst_dw", DW, 0);
        #20 rst_n = 1'b1;

        // basic burst
        start_burst(5'd4, 6'd3);
        feed(32'hA); feed(32'hB); feed(32'hC);
        check("basic_last_regen", RegEn, 1);
        expect_done();

        // wrap past 31, register 0 skipped
        start_burst(5'd30, 6'd4);
        feed(32'd1); feed(32'd2); feed(32'd3);
        check("zero_skip", RegEn, 0);
        feed(32'd4);
        expect_done();

        // illegal counts
        snap = regen_cnt;
        illegal(6'd0);
        illegal(6'd33);
        check("illegal_no_write", regen_cnt - snap, 0);

        // backpressure gaps
        snap = regen_cnt;
        start_burst(5'd12, 6'd2);
        feed(32'h11);
        repeat (2) begin
            @(negedge clk);
            check("gap_regen", RegEn, 0);
            check("gap_wr_hold", {27'd0, WR}, 12);
            check("gap_dw_hold", DW, 32'h11);
        end
        feed(32'h22);
        expect_done();
        check("gap_write_count", regen_cnt - snap, 2);

        // abort with the second handshake
        start_burst(5'd8, 6'd5);
        feed(32'hA0); feed(32'hA1, 1'b1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 0);
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_q_empty", exp_q.size(), 0);
        start_burst(5'd20, 6'd1);
        feed(32'h55);
        expect_done();

        // asynchronous reset mid-burst
        start_burst(5'd3, 6'd4);
        feed(32'h77);
        #2 rst_n = 1'b0;
        #1;
        check("arst_regen", RegEn, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", in_ready, 0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", in_ready, 0);
        start_burst(5'd5, 6'd1);
        feed(32'h99);
        expect_done();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
